controle_troca_ctx: RTL and testbench
=====================================

// Module: controle_troca_ctx
// PURPOSE
//  Initiator side of the context-switch interface. Counts retired instructions of the running user process;
//  on quantum expiry pulses troca_ctx to the PC manager and captures the preempted process's resume PC.
//  Holds a per-process PC/valid table that the OS reads to resume a process and writes to create one.
//  Sits beside the PC manager; the OS runs as id_proc==0 and is never preempted.
// PARAMETERS
//  QUANTUM  32  retired instructions per time slice (>=2)
//  N_PROC   4   table entries, indexed by id_proc (entry 0 = OS, never written by preemption)
//  PC_W     32  PC width
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous, active-high
//  id_proc      in   2     process currently executing (0 = OS)
//  instr_valida in   1     one instruction retired this cycle
//  atualPC      in   PC_W  current PC from PC manager
//  HALT         in   1     running process executes HALT this cycle
//  inicia_proc  in   1     OS pulse: jump into user process id_proc, start a new slice
//  wr_en        in   1     OS write into table
//  wr_id        in   2     entry to write
//  wr_pc        in   PC_W  PC value written; sets entry valid
//  rd_id        in   2     entry to read
//  troca_ctx    out  1     one-cycle preemption request to PC manager
//  rd_pc        out  PC_W  registered read data, 1-cycle latency
//  rd_valido    out  1     registered valid bit of rd_id entry
//  quantum_rest out  6     instructions left in slice (debug / OS accounting)
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1): state OCIOSO, counter=0, troca_ctx=0, rd_pc=0, rd_valido=0, all table
//   entries pc=0, valid=0; quantum_rest=QUANTUM. Reset overrides every other input in that cycle.
//  FSM states: OCIOSO, CONTANDO, TROCA, ESPERA_SO.
//   OCIOSO: counter held. inicia_proc && id_proc!=0 -> CONTANDO, counter=0.
//   CONTANDO: counter += instr_valida. If instr_valida && counter==QUANTUM-1 -> TROCA.
//     HALT -> ESPERA_SO; valid[id_proc] cleared; no troca_ctx. HALT wins over simultaneous expiry.
//     id_proc==0 (OS entered by other means) -> OCIOSO, no pulse.
//   TROCA: troca_ctx=1 for exactly this one cycle (registered output; no combinational path from inputs).
//     Same cycle: table[id_proc].pc <= atualPC (resume PC), valid <= 1.
//     HALT in this cycle: abort save; valid[id_proc] cleared; troca_ctx still 1 (PC manager gives HALT priority).
//     Next state ESPERA_SO.
//   ESPERA_SO: troca_ctx=0, counter held at 0. inicia_proc && id_proc!=0 -> CONTANDO, counter=0.
//  quantum_rest = QUANTUM - counter; equals QUANTUM outside CONTANDO.
//  Latency: expiring instr_valida at edge N -> troca_ctx high during cycle N+1 -> PC manager loads OS entry at N+2.
//  Table writes: wr_en writes table[wr_id] = {wr_pc, valid=1}. Same-cycle preemption save to same entry:
//   preemption save wins. wr_id==0 is legal (OS bookkeeping).
//  Table read: rd_pc/rd_valido registered from entry rd_id; read of entry written in the same cycle
//   returns the OLD value (no bypass).
//  inicia_proc while id_proc==0: ignored, state unchanged. inicia_proc in CONTANDO: restarts slice (counter=0).
//  Counter never wraps: saturates at QUANTUM-1 until the transition fires.
// STRUCTURE
//  Shared header defines_so.vh: ID_SO=0, PC_SO_HALT=67, PC_SO_TROCA=68, state encodings (2 bits).
//   Shared with the PC manager so OS entry PCs are defined once.
//  One sub-module: tabela_contexto (N_PROC x PC_W regs + valid bits, 1 sync write port, 1 priority save
//   port, 1 registered read port). FSM and quantum counter stay in controle_troca_ctx.
// TESTING
//  1 Reset mid-CONTANDO (counter=10): next cycle troca_ctx=0, quantum_rest=32, rd_valido=0 for all ids.
//  2 id_proc=2, inicia_proc, 32 instr_valida pulses, atualPC=0x40 in TROCA cycle -> troca_ctx high exactly
//    1 cycle, 1 cycle after 32nd pulse; read rd_id=2 -> rd_pc=0x40, rd_valido=1.
//  3 HALT coincident with 32nd instr_valida (id_proc=1) -> no troca_ctx; entry 1 rd_valido=0; state ESPERA_SO.
//  4 wr_en wr_id=3 wr_pc=0x100 same cycle as TROCA save for id_proc=3 atualPC=0x80 -> entry 3 reads 0x80.
//  5 id_proc=0 with 100 instr_valida pulses and inicia_proc -> troca_ctx never asserts, quantum_rest=32.
//  6 Gaps in instr_valida (every 3rd cycle) -> troca_ctx after exactly 32 retirements; restart via
//    inicia_proc in ESPERA_SO gives second pulse after another 32.

Source files
------------

// File: rtl/controle_troca_ctx_pkg.sv
// Shared definitions for the context-switch initiator: OS identity, OS entry PCs,
// FSM state encoding and the table save-port command.
package controle_troca_ctx_pkg;

  localparam int ID_W = 2;
  localparam int QR_W = 6;

  localparam logic [ID_W-1:0] ID_SO       = '0;
  localparam logic [31:0]     PC_SO_HALT  = 32'd67;
  localparam logic [31:0]     PC_SO_TROCA = 32'd68;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONTANDO  = 2'd1,
    TROCA     = 2'd2,
    ESPERA_SO = 2'd3
  } estado_t;

  // Save-port command; grava_pc=0 means "abort the save, clear the valid bit".
  typedef struct packed {
    logic            en;
    logic [ID_W-1:0] id;
    logic            grava_pc;
  } salva_t;

endpackage

// File: rtl/controle_troca_ctx_if.sv
// Context-switch bus between the PC manager / OS side (master) and the initiator (slave).
interface controle_troca_ctx_if #(
  parameter int PC_W = 32
);
  import controle_troca_ctx_pkg::*;

  logic [ID_W-1:0] id_proc;
  logic            instr_valida;
  logic [PC_W-1:0] atualPC;
  logic            HALT;
  logic            inicia_proc;
  logic            wr_en;
  logic [ID_W-1:0] wr_id;
  logic [PC_W-1:0] wr_pc;
  logic [ID_W-1:0] rd_id;
  logic            troca_ctx;
  logic [PC_W-1:0] rd_pc;
  logic            rd_valido;
  logic [QR_W-1:0] quantum_rest;

  modport master (
    output id_proc, instr_valida, atualPC, HALT, inicia_proc,
           wr_en, wr_id, wr_pc, rd_id,
    input  troca_ctx, rd_pc, rd_valido, quantum_rest
  );

  modport slave (
    input  id_proc, instr_valida, atualPC, HALT, inicia_proc,
           wr_en, wr_id, wr_pc, rd_id,
    output troca_ctx, rd_pc, rd_valido, quantum_rest
  );

endinterface

// File: rtl/controle_troca_ctx_tabela.sv
// Per-process resume table: PC + valid per entry, one OS write port, one priority
// save port from the preemption FSM, one registered read port without bypass.
module tabela_contexto
  import controle_troca_ctx_pkg::*;
#(
  parameter int N_PROC = 4,
  parameter int PC_W   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_id,
  input  logic [PC_W-1:0] wr_pc,
  input  salva_t          salva,
  input  logic [PC_W-1:0] salva_pc,
  input  logic [ID_W-1:0] rd_id,
  output logic [PC_W-1:0] rd_pc,
  output logic            rd_valido
);

  logic [PC_W-1:0] pc_q [N_PROC];
  logic [PC_W-1:0] pc_d [N_PROC];
  logic [N_PROC-1:0] valido_q, valido_d;
  logic [PC_W-1:0] rd_pc_q, rd_pc_d;
  logic            rd_valido_q, rd_valido_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    pc_d     = pc_q;
    valido_d = valido_q;
    if (wr_en) begin
      pc_d[wr_id]     = wr_pc;
      valido_d[wr_id] = 1'b1;
    end
    // Applied after the OS write so a preemption save to the same entry wins.
    if (salva.en) begin
      if (salva.grava_pc) begin
        pc_d[salva.id]     = salva_pc;
        valido_d[salva.id] = 1'b1;
      end else begin
        valido_d[salva.id] = 1'b0;
      end
    end
    rd_pc_d     = pc_q[rd_id];
    rd_valido_d = valido_q[rd_id];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is a small flop array, so it is reset; valid bits must never start unknown.
      for (int i = 0; i < N_PROC; i++) pc_q[i] <= '0;
      valido_q    <= '0;
      rd_pc_q     <= '0;
      rd_valido_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      valido_q    <= valido_d;
      rd_pc_q     <= rd_pc_d;
      rd_valido_q <= rd_valido_d;
    end
  end

  assign rd_pc     = rd_pc_q;
  assign rd_valido = rd_valido_q;

endmodule

// File: rtl/controle_troca_ctx.sv
// Quantum counter and preemption FSM for user processes; requests a context switch
// on slice expiry and saves the preempted process's resume PC into tabela_contexto.
module controle_troca_ctx
  import controle_troca_ctx_pkg::*;
#(
  parameter int QUANTUM = 32,
  parameter int N_PROC  = 4,
  parameter int PC_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  controle_troca_ctx_if.slave  bus
);

  localparam logic [QR_W-1:0] QUANTUM_V = QR_W'(QUANTUM);
  localparam logic [QR_W-1:0] ULTIMO    = QR_W'(QUANTUM - 1);

  estado_t         state_q, state_d;
  logic [QR_W-1:0] counter_q, counter_d;
  logic            troca_ctx_q, troca_ctx_d;
  salva_t          salva;
  logic            usuario;

  assign usuario = (bus.id_proc != ID_SO);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q     <= OCIOSO;
      counter_q   <= '0;
      troca_ctx_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      troca_ctx_q <= troca_ctx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    unique case (state_q)
      OCIOSO, ESPERA_SO: begin
        counter_d = '0;
        if (bus.inicia_proc && usuario) state_d = CONTANDO;
      end
      CONTANDO: begin
        // OS running means no user slice to account; HALT then beats restart and expiry.
        if (!usuario) begin
          state_d   = OCIOSO;
          counter_d = '0;
        end else if (bus.HALT) begin
          state_d   = ESPERA_SO;
          counter_d = '0;
        end else if (bus.inicia_proc) begin
          counter_d = '0;
        end else if (bus.instr_valida) begin
          if (counter_q == ULTIMO) begin
            state_d   = TROCA;
            counter_d = '0;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end
      TROCA: begin
        state_d   = ESPERA_SO;
        counter_d = '0;
      end
      default: begin
        state_d   = OCIOSO;
        counter_d = '0;
      end
    endcase
  end

  always_comb begin
    troca_ctx_d = (state_d == TROCA);
    salva       = '0;
    if (usuario) begin
      if (state_q == TROCA) begin
        salva.en       = 1'b1;
        salva.id       = bus.id_proc;
        salva.grava_pc = !bus.HALT;
      end else if (state_q == CONTANDO && bus.HALT) begin
        salva.en       = 1'b1;
        salva.id       = bus.id_proc;
        salva.grava_pc = 1'b0;
      end
    end
    bus.quantum_rest = (state_q == CONTANDO) ? QUANTUM_V - counter_q : QUANTUM_V;
  end

  assign bus.troca_ctx = troca_ctx_q;

  tabela_contexto #(
    .N_PROC (N_PROC),
    .PC_W   (PC_W)
  ) u_tabela (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.wr_en),
    .wr_id     (bus.wr_id),
    .wr_pc     (bus.wr_pc),
    .salva     (salva),
    .salva_pc  (bus.atualPC),
    .rd_id     (bus.rd_id),
    .rd_pc     (bus.rd_pc),
    .rd_valido (bus.rd_valido)
  );

endmodule

// File: tb/tb_controle_troca_ctx.sv
// Bench for controle_troca_ctx: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a slice-accounting model.
module tb_controle_troca_ctx;
  import controle_troca_ctx_pkg::*;

  localparam int QUANTUM = 32;
  localparam int N_PROC  = 4;
  localparam int PC_W    = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controle_troca_ctx_if #(.PC_W(PC_W)) bus ();

  controle_troca_ctx #(
    .QUANTUM (QUANTUM),
    .N_PROC  (N_PROC),
    .PC_W    (PC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a user slice is either active with m_left instructions remaining, or not.
  bit              m_active;
  int              m_left;
  bit              m_pulse;
  logic [PC_W-1:0] m_pc [N_PROC];
  bit              m_v  [N_PROC];
  logic [PC_W-1:0] m_rd_pc;
  bit              m_rd_v;
  bit              model_ok = 1'b0;

  task automatic model_step();
    int id;
    id = int'(bus.id_proc);
    if (reset) begin
      m_active = 1'b0;
      m_left   = QUANTUM;
      m_pulse  = 1'b0;
      for (int i = 0; i < N_PROC; i++) begin
        m_pc[i] = '0;
        m_v[i]  = 1'b0;
      end
      m_rd_pc  = '0;
      m_rd_v   = 1'b0;
      model_ok = 1'b1;
      return;
    end
    m_rd_pc = m_pc[bus.rd_id];
    m_rd_v  = m_v[bus.rd_id];
    if (bus.wr_en) begin
      m_pc[bus.wr_id] = bus.wr_pc;
      m_v[bus.wr_id]  = 1'b1;
    end
    if (m_pulse) begin
      m_pulse = 1'b0;
      if (id != 0) begin
        if (bus.HALT) m_v[id] = 1'b0;
        else begin
          m_pc[id] = bus.atualPC;
          m_v[id]  = 1'b1;
        end
      end
    end else if (m_active) begin
      if (id == 0) m_active = 1'b0;
      else if (bus.HALT) begin
        m_v[id]  = 1'b0;
        m_active = 1'b0;
      end else if (bus.inicia_proc) m_left = QUANTUM;
      else if (bus.instr_valida) begin
        if (m_left == 1) begin
          m_active = 1'b0;
          m_pulse  = 1'b1;
        end else m_left--;
      end
    end else if (bus.inicia_proc && id != 0) begin
      m_active = 1'b1;
      m_left   = QUANTUM;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("cmp_troca_ctx", bus.troca_ctx, m_pulse);
      check("cmp_quantum_rest", bus.quantum_rest, m_active ? m_left : QUANTUM);
      check("cmp_rd_pc", bus.rd_pc, m_rd_pc);
      check("cmp_rd_valido", bus.rd_valido, m_rd_v);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_valida = 1'b0;
    bus.HALT         = 1'b0;
    bus.inicia_proc  = 1'b0;
    bus.wr_en        = 1'b0;
  endtask

  task automatic start_slice(input logic [ID_W-1:0] id);
    bus.id_proc     = id;
    bus.inicia_proc = 1'b1;
    tick();
    bus.inicia_proc = 1'b0;
  endtask

  task automatic gap_slice(input string tag);
    int ret;
    ret = 0;
    for (int cyc = 0; cyc < 200 && ret < QUANTUM; cyc++) begin
      bus.instr_valida = (cyc % 3 == 2);
      tick();
      if (bus.instr_valida) ret++;
      if (ret < QUANTUM) check({tag, "_no_early_pulse"}, bus.troca_ctx, 1'b0);
    end
    bus.instr_valida = 1'b0;
    check({tag, "_pulse_after_32"}, bus.troca_ctx, 1'b1);
    tick();
    check({tag, "_pulse_one_cycle"}, bus.troca_ctx, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.id_proc  = '0;
    bus.atualPC  = '0;
    bus.wr_id    = '0;
    bus.wr_pc    = '0;
    bus.rd_id    = '0;
    idle_inputs();
    tick();
    reset = 1'b0;

    // 1: reset mid-slice clears counter, pulse and table
    bus.wr_en = 1'b1; bus.wr_id = 2'd3; bus.wr_pc = 32'h55;
    tick();
    bus.wr_en = 1'b0;
    start_slice(2'd1);
    bus.instr_valida = 1'b1;
    repeat (10) tick();
    bus.instr_valida = 1'b0;
    check("t1_qr_mid_slice", bus.quantum_rest, 22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t1_troca_after_reset", bus.troca_ctx, 1'b0);
    check("t1_qr_after_reset", bus.quantum_rest, 32);
    for (int i = 0; i < N_PROC; i++) begin
      bus.rd_id = ID_W'(i);
      tick();
      check("t1_rd_valido_cleared", bus.rd_valido, 1'b0);
    end

    // 2: full slice for process 2, resume PC saved
    start_slice(2'd2);
    bus.instr_valida = 1'b1;
    repeat (QUANTUM - 1) tick();
    check("t2_no_pulse_before_32", bus.troca_ctx, 1'b0);
    check("t2_qr_last", bus.quantum_rest, 1);
    bus.atualPC = 32'h40;
    tick();
    bus.instr_valida = 1'b0;
    check("t2_pulse", bus.troca_ctx, 1'b1);
    tick();
    check("t2_pulse_single", bus.troca_ctx, 1'b0);
    check("t2_qr_waiting", bus.quantum_rest, 32);
    bus.rd_id = 2'd2;
    tick();
    check("t2_rd_pc", bus.rd_pc, 32'h40);
    check("t2_rd_valido", bus.rd_valido, 1'b1);

    // 3: HALT together with the expiring instruction
    bus.wr_en = 1'b1; bus.wr_id = 2'd1; bus.wr_pc = 32'h11;
    tick();
    bus.wr_en = 1'b0;
    start_slice(2'd1);
    bus.instr_valida = 1'b1;
    repeat (QUANTUM - 1) tick();
    bus.HALT = 1'b1;
    tick();
    bus.HALT = 1'b0;
    check("t3_no_pulse_on_halt", bus.troca_ctx, 1'b0);
    check("t3_qr_after_halt", bus.quantum_rest, 32);
    repeat (3) tick();
    bus.instr_valida = 1'b0;
    check("t3_waiting_holds", bus.quantum_rest, 32);
    check("t3_still_no_pulse", bus.troca_ctx, 1'b0);
    bus.rd_id = 2'd1;
    tick();
    check("t3_entry1_invalid", bus.rd_valido, 1'b0);

    // 4: OS write and preemption save to the same entry in the same cycle
    start_slice(2'd3);
    bus.instr_valida = 1'b1;
    repeat (QUANTUM) tick();
    bus.instr_valida = 1'b0;
    check("t4_pulse", bus.troca_ctx, 1'b1);
    bus.atualPC = 32'h80;
    bus.wr_en = 1'b1; bus.wr_id = 2'd3; bus.wr_pc = 32'h100;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_id = 2'd3;
    tick();
    check("t4_save_wins", bus.rd_pc, 32'h80);
    check("t4_valid", bus.rd_valido, 1'b1);

    // 5: the OS is never preempted
    bus.id_proc      = ID_SO;
    bus.inicia_proc  = 1'b1;
    bus.instr_valida = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.troca_ctx !== 1'b0) check("t5_os_no_pulse", bus.troca_ctx, 1'b0);
    end
    idle_inputs();
    check("t5_qr_os", bus.quantum_rest, 32);

    // 6: sparse retirements, then a restarted second slice
    start_slice(2'd2);
    gap_slice("t6a");
    tick();
    start_slice(2'd2);
    gap_slice("t6b");

    // Randomized run; the per-cycle comparator carries the checking
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 99) == 0)
        bus.id_proc = ($urandom_range(0, 7) == 0) ? ID_SO : ID_W'($urandom_range(1, 3));
      bus.instr_valida = ($urandom_range(0, 9) < 7);
      bus.HALT         = ($urandom_range(0, 199) == 0);
      bus.inicia_proc  = ($urandom_range(0, 199) < 3);
      bus.atualPC      = $urandom;
      bus.wr_en        = ($urandom_range(0, 4) == 0);
      bus.wr_id        = ID_W'($urandom_range(0, 3));
      bus.wr_pc        = $urandom;
      bus.rd_id        = ID_W'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
